serial_operand_transmitter: RTL and testbench
=============================================

// Module: serial_operand_transmitter
// PURPOSE
//   Parallel-to-serial front end for the sequential unsigned comparator FSM.
//   Captures two WIDTH-bit unsigned operands, streams them bit-pairwise (LSB first)
//   on b1/b2 under a valid/ready handshake, then raises OP for one cycle to close the session.
//   Sits between the operand source and the comparator; replaces bench-driven load/OP sequencing.
// PARAMETERS
//   WIDTH   32   operand width in bits; legal range 1..64
// PORTS
//   clk      in   1      system clock; all state updates on the rising edge
//   rst      in   1      asynchronous, active-high reset
//   x1       in   WIDTH  first operand (unsigned)
//   x2       in   WIDTH  second operand (unsigned)
//   start    in   1      request a session; sampled only in IDLE
//   ready    in   1      downstream accepts the current bit pair this cycle
//   b1       out  1      serial bit of x1
//   b2       out  1      serial bit of x2
//   valid    out  1      b1/b2 carry a live bit pair
//   OP       out  1      end-of-session flag; one-cycle pulse after the last bit pair
//   busy     out  1      high from capture until OP is issued
// BEHAVIOUR
//   - Reset values (async, immediate): state=IDLE; b1=b2=valid=OP=busy=0; shift regs and counter = 0.
//   - All outputs are registered. There is no combinational path from an input to an output.
//   - States: IDLE -> SHIFT -> END -> IDLE.
//   - IDLE: on the edge where start=1, capture x1/x2, clear cnt, go to SHIFT. Set busy=1 and valid=1.
//     Bit 0 of each operand is on b1/b2 from that edge on. Latency start->first valid = 1 cycle.
//   - SHIFT: a transfer occurs on an edge with valid&&ready. On each transfer, shift both registers
//     and increment cnt. b1/b2/valid stay stable while ready=0 (stall; no bit is lost or repeated).
//   - When the transfer of bit WIDTH-1 occurs, go to END: valid=0, OP=1.
//   - END: lasts exactly one cycle. Then OP=0, busy=0, go to IDLE.
//     A new start may be accepted on the edge that enters IDLE, or later.
//   - start while busy is ignored. x1/x2 changes after capture have no effect.
//   - cnt width is $clog2(WIDTH+1) and it never wraps. WIDTH=1 gives SHIFT for one transfer, then END.
//   - Minimum session length = WIDTH+2 cycles (start edge, WIDTH transfers, END).
//   - Reset mid-session aborts at once. No OP is issued for an aborted session.
//   - ready in IDLE/END is ignored. start and ready may both be high; they do not interact.
// CONFIGURATION
//   SER_MSB_FIRST_EN defined: operands are streamed MSB first (bit WIDTH-1 first).
//     Used with the MSB-first comparator variant. cnt, OP and handshake are unchanged.
//   Undefined (default): LSB first, as the bit-serial comparator FSM requires.
// STRUCTURE
//   Shared package seq_cmp_pkg:
//     - state encoding constants S_IDLE=2'b00, S_SHIFT=2'b01, S_END=2'b10
//     - DEFAULT_WIDTH=32
//     - compare-result codes (GT/EQ/LT), so the transmitter and comparator agree
//   Sub-module piso_shift_reg #(WIDTH): load, shift_en, serial out.
//     Two instances, one per operand. Shift direction follows SER_MSB_FIRST_EN.
//   Top level holds the FSM, cnt, and output registers.
// TESTING
//   1 Equal operands: WIDTH=32, x1=x2=32'hB42D8C3D, ready=1 constant.
//     -> b1==b2 on all 32 valid cycles; OP pulses at cycle 33 after start; busy falls with it.
//   2 Ordering: x1=32'h00000001, x2=32'h80000000, ready=1.
//     -> first pair (b1,b2)=(1,0), last pair=(0,1).
//     With SER_MSB_FIRST_EN the order is reversed.
//   3 Stall: WIDTH=8, x1=8'hA5, x2=8'h3C, ready toggled 1,0,0,1,...
//     -> captured stream is exactly A5/3C LSB first; b1/b2 hold during ready=0;
//     OP follows the 8th accepted transfer.
//   4 Ignored start: pulse start with x1=8'hFF mid-session of test 3 -> stream unchanged; no re-capture.
//   5 Reset abort: assert rst after 5 transfers.
//     -> all outputs 0 immediately; no OP; a fresh start then completes normally.
//   6 Loopback: drive the comparator FSM from b1/b2/valid/OP for GT/EQ/LT operand sets.
//     -> compare matches x1 vs x2 for each set.

Source files
------------

// File: rtl/seq_cmp_pkg.sv
// seq_cmp_pkg: shared constants for the serial operand transmitter and the bit-serial comparator.
package seq_cmp_pkg;
    localparam int DEFAULT_WIDTH = 32;
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_END   = 2'b10;
    typedef enum logic [1:0] {CMP_EQ = 2'b00, CMP_GT = 2'b01, CMP_LT = 2'b10} cmp_res_e;
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: loadable shift register that presents one operand bit per shift.
// Streams LSB first by default, MSB first when SER_MSB_FIRST_EN is defined.
module piso_shift_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_en_i,
    output logic             ser_o
);
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] shifted;
`ifdef SER_MSB_FIRST_EN
    assign shifted = sr_q << 1;
    assign ser_o   = sr_q[WIDTH-1];
`else
    assign shifted = sr_q >> 1;
    assign ser_o   = sr_q[0];
`endif
    always_comb sr_d = load_i ? data_i : shift_en_i ? shifted : sr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end
endmodule

// File: rtl/serial_operand_transmitter.sv
// serial_operand_transmitter: streams two captured operands bit-pairwise under valid/ready, then pulses OP.
// Define SER_MSB_FIRST_EN to stream MSB first instead of LSB first.
module serial_operand_transmitter
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic             start,
    input  logic             ready,
    output logic             b1,
    output logic             b2,
    output logic             valid,
    output logic             OP,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          op_q, op_d;
    logic          busy_q, busy_d;
    logic          load;
    logic          shift;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        op_d    = 1'b0;
        busy_d  = busy_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                load    = 1'b1;
                cnt_d   = '0;
                valid_d = 1'b1;
                busy_d  = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: if (ready) begin
                shift = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_END;
                    valid_d = 1'b0;
                    op_d    = 1'b1;
                end
            end
            S_END: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            op_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
        end
    end
    // The shift registers drain to zero, so b1/b2 idle low after a session.
    piso_shift_reg #(.WIDTH(WIDTH)) u_sr1 (
        .clk(clk), .rst(rst), .load_i(load), .data_i(x1), .shift_en_i(shift), .ser_o(b1)
    );
    piso_shift_reg #(.WIDTH(WIDTH)) u_sr2 (
        .clk(clk), .rst(rst), .load_i(load), .data_i(x2), .shift_en_i(shift), .ser_o(b2)
    );
    assign valid = valid_q;
    assign OP    = op_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_serial_operand_transmitter.sv
// tb_serial_operand_transmitter: directed checks of a 32-bit and an 8-bit transmitter instance.
module tb_serial_operand_transmitter;
    import seq_cmp_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] x1a = '0, x2a = '0;
    logic start_a = 1'b0, ready_a = 1'b0;
    logic b1a, b2a, valid_a, op_a, busy_a;
    logic [7:0] x1b = '0, x2b = '0;
    logic start_b = 1'b0, ready_b = 1'b0;
    logic b1b, b2b, valid_b, op_b, busy_b;
    int total = 0;
    int bad = 0;
    logic r_b1[0:35], r_b2[0:35], r_v[0:35], r_op[0:35], r_busy[0:35];
    always #5 clk = ~clk;
    serial_operand_transmitter #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .x1(x1a), .x2(x2a), .start(start_a), .ready(ready_a),
        .b1(b1a), .b2(b2a), .valid(valid_a), .OP(op_a), .busy(busy_a)
    );
    serial_operand_transmitter #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .x1(x1b), .x2(x2b), .start(start_b), .ready(ready_b),
        .b1(b1b), .b2(b2b), .valid(valid_b), .OP(op_b), .busy(busy_b)
    );
    function automatic logic eb(logic [31:0] v, int w, int i);
`ifdef SER_MSB_FIRST_EN
        return v[w-1-i];
`else
        return v[i];
`endif
    endfunction
    // Runs one 32-bit session with ready=1; r_*[c] holds outputs after the c-th edge from the start edge.
    task automatic run32(input logic [31:0] a, input logic [31:0] b);
        x1a = a;
        x2a = b;
        start_a = 1'b1;
        ready_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 36; c++) begin
            r_b1[c] = b1a;
            r_b2[c] = b2a;
            r_v[c] = valid_a;
            r_op[c] = op_a;
            r_busy[c] = busy_a;
            @(negedge clk);
        end
        ready_a = 1'b0;
    endtask
    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if ({b1a, b2a, valid_a, op_a, busy_a} !== 5'b0) begin
            bad++;
            $display("FAIL reset32 got=%b want=00000", {b1a, b2a, valid_a, op_a, busy_a});
        end
        total++;
        if ({b1b, b2b, valid_b, op_b, busy_b} !== 5'b0) begin
            bad++;
            $display("FAIL reset8 got=%b want=00000", {b1b, b2b, valid_b, op_b, busy_b});
        end
        rst = 1'b0;
    endtask
    task automatic test_equal;
        logic [31:0] v = 32'hB42D8C3D;
        run32(v, v);
        for (int i = 0; i < 32; i++) begin
            total++;
            if (r_v[i] !== 1'b1 || r_b1[i] !== eb(v, 32, i) || r_b2[i] !== r_b1[i] || r_op[i] !== 1'b0 || r_busy[i] !== 1'b1) begin
                bad++;
                $display("FAIL equal_bit%0d got v=%b b1=%b b2=%b op=%b busy=%b want v=1 b1=b2=%b op=0 busy=1",
                         i, r_v[i], r_b1[i], r_b2[i], r_op[i], r_busy[i], eb(v, 32, i));
            end
        end
        total++;
        if ({r_v[32], r_op[32], r_busy[32]} !== 3'b011) begin
            bad++;
            $display("FAIL equal_end got v/op/busy=%b want 011", {r_v[32], r_op[32], r_busy[32]});
        end
        total++;
        if ({r_v[33], r_op[33], r_busy[33]} !== 3'b000) begin
            bad++;
            $display("FAIL equal_idle got v/op/busy=%b want 000", {r_v[33], r_op[33], r_busy[33]});
        end
    endtask
    task automatic test_ordering;
        run32(32'h0000_0001, 32'h8000_0000);
        total++;
        if ({r_b1[0], r_b2[0]} !== {eb(32'h1, 32, 0), eb(32'h8000_0000, 32, 0)}) begin
            bad++;
            $display("FAIL order_first got=%b%b want=%b%b", r_b1[0], r_b2[0], eb(32'h1, 32, 0), eb(32'h8000_0000, 32, 0));
        end
        total++;
        if ({r_b1[31], r_b2[31]} !== {eb(32'h1, 32, 31), eb(32'h8000_0000, 32, 31)}) begin
            bad++;
            $display("FAIL order_last got=%b%b want=%b%b", r_b1[31], r_b2[31], eb(32'h1, 32, 31), eb(32'h8000_0000, 32, 31));
        end
    endtask
    task automatic test_loopback;
        logic [31:0] ta[3] = '{32'h0001_0000, 32'h1234_5678, 32'hFFFF_FFFE};
        logic [31:0] tb[3] = '{32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_FFFF};
        cmp_res_e want[3] = '{CMP_GT, CMP_EQ, CMP_LT};
        cmp_res_e res;
        for (int s = 0; s < 3; s++) begin
            run32(ta[s], tb[s]);
            res = CMP_EQ;
            for (int c = 0; c < 36; c++) begin
`ifdef SER_MSB_FIRST_EN
                if (r_v[c] && res == CMP_EQ && r_b1[c] != r_b2[c]) res = r_b1[c] ? CMP_GT : CMP_LT;
`else
                if (r_v[c] && r_b1[c] != r_b2[c]) res = r_b1[c] ? CMP_GT : CMP_LT;
`endif
            end
            total++;
            if (res !== want[s] || r_op[32] !== 1'b1) begin
                bad++;
                $display("FAIL loopback%0d got res=%0d op=%b want res=%0d op=1", s, res, r_op[32], want[s]);
            end
        end
    endtask
    task automatic test_stall(input bit poke);
        logic [3:0] pat = 4'b1001;
        logic hold = 1'b0;
        logic [1:0] saved = '0;
        int j = 0;
        int k = 0;
        x1b = 8'hA5;
        x2b = 8'h3C;
        start_b = 1'b1;
        ready_b = 1'b0;
        @(negedge clk);
        start_b = 1'b0;
        while (j < 8 && k < 100) begin
            ready_b = pat[k % 4];
            start_b = poke && k == 5;
            if (poke && k >= 5) x1b = 8'hFF;
            total++;
            if ({valid_b, op_b, busy_b} !== 3'b101) begin
                bad++;
                $display("FAIL stall_flags k=%0d got v/op/busy=%b want 101", k, {valid_b, op_b, busy_b});
            end
            if (hold) begin
                total++;
                if ({b1b, b2b} !== saved) begin
                    bad++;
                    $display("FAIL stall_hold k=%0d got=%b want=%b", k, {b1b, b2b}, saved);
                end
            end
            if (ready_b) begin
                total++;
                if ({b1b, b2b} !== {eb(32'hA5, 8, j), eb(32'h3C, 8, j)}) begin
                    bad++;
                    $display("FAIL stall_bit%0d got=%b want=%b%b", j, {b1b, b2b}, eb(32'hA5, 8, j), eb(32'h3C, 8, j));
                end
                j++;
                hold = 1'b0;
            end else begin
                hold = 1'b1;
                saved = {b1b, b2b};
            end
            @(negedge clk);
            k++;
        end
        start_b = 1'b0;
        ready_b = 1'b0;
        x1b = 8'hA5;
        total++;
        if (j != 8) begin
            bad++;
            $display("FAIL stall_timeout got transfers=%0d want 8", j);
        end
        total++;
        if ({valid_b, op_b, busy_b} !== 3'b011) begin
            bad++;
            $display("FAIL stall_end got v/op/busy=%b want 011", {valid_b, op_b, busy_b});
        end
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({valid_b, op_b, busy_b} !== 3'b000) begin
                bad++;
                $display("FAIL stall_idle poke=%0d got v/op/busy=%b want 000", poke, {valid_b, op_b, busy_b});
            end
        end
    endtask
    task automatic test_ignored_start;
        test_stall(1'b1);
    endtask
    task automatic test_reset_abort;
        x1b = 8'hA5;
        x2b = 8'h3C;
        start_b = 1'b1;
        ready_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({b1b, b2b, valid_b, op_b, busy_b} !== 5'b0) begin
            bad++;
            $display("FAIL abort_immediate got=%b want=00000", {b1b, b2b, valid_b, op_b, busy_b});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            total++;
            if ({valid_b, op_b, busy_b} !== 3'b000) begin
                bad++;
                $display("FAIL abort_no_op got v/op/busy=%b want 000", {valid_b, op_b, busy_b});
            end
        end
        x1b = 8'h5A;
        x2b = 8'hC3;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({valid_b, b1b, b2b} !== {1'b1, eb(32'h5A, 8, i), eb(32'hC3, 8, i)}) begin
                bad++;
                $display("FAIL fresh_bit%0d got v/b1/b2=%b want 1%b%b", i, {valid_b, b1b, b2b}, eb(32'h5A, 8, i), eb(32'hC3, 8, i));
            end
            @(negedge clk);
        end
        total++;
        if ({valid_b, op_b, busy_b} !== 3'b011) begin
            bad++;
            $display("FAIL fresh_end got v/op/busy=%b want 011", {valid_b, op_b, busy_b});
        end
        @(negedge clk);
        ready_b = 1'b0;
        total++;
        if ({valid_b, op_b, busy_b} !== 3'b000) begin
            bad++;
            $display("FAIL fresh_idle got v/op/busy=%b want 000", {valid_b, op_b, busy_b});
        end
    endtask
    initial begin
        test_reset();
        test_equal();
        test_ordering();
        test_loopback();
        test_stall(1'b0);
        test_ignored_start();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
